// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller.
//   FWD_*     : EX operand forwarding select encodings.
//   MD_CNT_W  : width of the mul/div busy-window counter.
//   fwd_pick  : turns MEM/WB hit flags into a forwarding select, MEM first.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MD_CNT_W = 4;

  // MEM holds the younger result, so it wins over WB.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// Busy-window tracker for the multi-cycle mul/div unit.
//   clk, rst_n : pipeline clock, asynchronous active-low reset.
//   start      : mul/div issuing from EX this cycle; (re)loads the window.
//   busy       : registered flag, high for MD_LATENCY cycles after start.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MD_LATENCY);

  logic [MD_CNT_W-1:0] cnt_reg;
  logic [MD_CNT_W-1:0] cnt_next;
  logic                busy_reg;

  // A start while still busy simply restarts the window.
  always_comb begin
    cnt_next = cnt_reg;
    if (start) begin
      cnt_next = LAT;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // busy is registered from the next count so it is glitch-free and
  // high exactly while the loaded window is still open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      busy_reg <= (cnt_next != '0);
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
//   Inputs : ID/EX/MEM/WB register addresses, read/write enables, load and
//            mul/div indications, branch-taken from EX.
//   Outputs: ex_forward_a/b (00 RF, 01 WB, 10 MEM), stall_if/stall_id,
//            flush_id/flush_ex, md_busy, saturating stall_cnt.
// Forwarding, stall and flush are purely combinational; md_busy and
// stall_cnt are registered.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rt_a,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_md_read,
  input  logic              id_md_start,
  input  logic [REG_AW-1:0] ex_rs_a,
  input  logic [REG_AW-1:0] ex_rt_a,
  input  logic [REG_AW-1:0] ex_rd_a,
  input  logic              ex_MemRead,
  input  logic              ex_md_start,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd_a,
  input  logic [REG_AW-1:0] wb_rd_a,
  input  logic              mem_RegWrite,
  input  logic              wb_RegWrite,
  output logic [1:0]        ex_forward_a,
  output logic [1:0]        ex_forward_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              md_busy,
  output logic [STAT_W-1:0] stall_cnt
);

  // Operand 0 is rs (select a), operand 1 is rt (select b).
  logic [1:0][REG_AW-1:0] ex_src;
  logic [1:0][1:0]        fwd_sel;

  assign ex_src[0] = ex_rs_a;
  assign ex_src[1] = ex_rt_a;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      // Register 0 is hardwired to zero and never forwards.
      assign mem_hit = mem_RegWrite && (mem_rd_a != '0) && (mem_rd_a == ex_src[gi]);
      assign wb_hit  = wb_RegWrite  && (wb_rd_a  != '0) && (wb_rd_a  == ex_src[gi]);
      assign fwd_sel[gi] = fwd_pick(mem_hit, wb_hit);
    end
  endgenerate

  assign ex_forward_a = fwd_sel[0];
  assign ex_forward_b = fwd_sel[1];

  md_busy_tracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ex_md_start),
    .busy  (md_busy)
  );

  logic load_use;
  logic md_hazard;
  logic stall_req;

  assign load_use  = ex_MemRead && (ex_rd_a != '0) &&
                     ((id_uses_rs && (ex_rd_a == id_rs_a)) ||
                      (id_uses_rt && (ex_rd_a == id_rt_a)));
  assign md_hazard = md_busy && (id_md_read || id_md_start);
  assign stall_req = load_use || md_hazard;

  // A taken branch kills the stalled instruction in ID anyway, so it
  // overrides the stall and just flushes both wrong-path slots.
  assign stall_if = stall_req && !ex_branch_taken;
  assign stall_id = stall_req && !ex_branch_taken;
  assign flush_id = ex_branch_taken;
  assign flush_ex = ex_branch_taken || stall_req;

  logic [STAT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_id && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance (STAT_W=16) and a
// narrow-counter instance (STAT_W=3) share all inputs. A cycle-level
// model is compared against the DUT on every falling edge; directed
// literal checks pin the model at the interesting points.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs_a, id_rt_a, ex_rs_a, ex_rt_a, ex_rd_a, mem_rd_a, wb_rd_a;
  logic       id_uses_rs, id_uses_rt, id_md_read, id_md_start;
  logic       ex_MemRead, ex_md_start, ex_branch_taken, mem_RegWrite, wb_RegWrite;

  logic [1:0]  fa, fb, fa_s, fb_s;
  logic        sif, sid, fid, fex, mdb;
  logic        sif_s, sid_s, fid_s, fex_s, mdb_s;
  logic [15:0] scnt;
  logic [2:0]  scnt_s;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .MD_LATENCY(LAT), .STAT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_a(id_rs_a), .id_rt_a(id_rt_a), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_read(id_md_read), .id_md_start(id_md_start),
    .ex_rs_a(ex_rs_a), .ex_rt_a(ex_rt_a), .ex_rd_a(ex_rd_a), .ex_MemRead(ex_MemRead),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_rd_a(mem_rd_a), .wb_rd_a(wb_rd_a), .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
    .ex_forward_a(fa), .ex_forward_b(fb), .stall_if(sif), .stall_id(sid),
    .flush_id(fid), .flush_ex(fex), .md_busy(mdb), .stall_cnt(scnt)
  );

  hazard_ctrl #(.REG_AW(5), .MD_LATENCY(LAT), .STAT_W(3)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .id_rs_a(id_rs_a), .id_rt_a(id_rt_a), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_read(id_md_read), .id_md_start(id_md_start),
    .ex_rs_a(ex_rs_a), .ex_rt_a(ex_rt_a), .ex_rd_a(ex_rd_a), .ex_MemRead(ex_MemRead),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_rd_a(mem_rd_a), .wb_rd_a(wb_rd_a), .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
    .ex_forward_a(fa_s), .ex_forward_b(fb_s), .stall_if(sif_s), .stall_id(sid_s),
    .flush_id(fid_s), .flush_ex(fex_s), .md_busy(mdb_s), .stall_cnt(scnt_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The mul/div busy window is kept as "last busy cycle number", the
  // stall counts as plain integers clipped at each instance's maximum.
  int cyc    = 0;
  int md_end = -1;
  int cnt16  = 0;
  int cnt3   = 0;
  bit cmp_en = 1'b0;

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (mem_RegWrite && mem_rd_a != 0 && mem_rd_a == src) return 2'b10;
    if (wb_RegWrite && wb_rd_a != 0 && wb_rd_a == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_busy();
    return cyc <= md_end;
  endfunction

  function automatic bit m_stall();
    bit lu;
    lu = ex_MemRead && ex_rd_a != 0 &&
         ((id_uses_rs && ex_rd_a == id_rs_a) || (id_uses_rt && ex_rd_a == id_rt_a));
    return (lu || (m_busy() && (id_md_read || id_md_start))) && !ex_branch_taken;
  endfunction

  function automatic bit m_flush_ex();
    return ex_branch_taken || m_stall() ||
           (ex_MemRead && ex_rd_a != 0 &&
            ((id_uses_rs && ex_rd_a == id_rs_a) || (id_uses_rt && ex_rd_a == id_rt_a))) ||
           (m_busy() && (id_md_read || id_md_start));
  endfunction

  always @(negedge rst_n) begin
    md_end = -1;
    cnt16  = 0;
    cnt3   = 0;
  end

  always @(posedge clk) begin
    bit s;
    s = m_stall();
    cyc++;
    if (!rst_n) begin
      md_end = -1;
      cnt16  = 0;
      cnt3   = 0;
    end else begin
      if (s) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt3 < 7) cnt3++;
      end
      if (ex_md_start) md_end = cyc + LAT - 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("m_fwd_a",    32'(fa),     32'(m_fwd(ex_rs_a)));
      cmp("m_fwd_b",    32'(fb),     32'(m_fwd(ex_rt_a)));
      cmp("m_stall_if", 32'(sif),    32'(m_stall()));
      cmp("m_stall_id", 32'(sid),    32'(m_stall()));
      cmp("m_flush_id", 32'(fid),    32'(ex_branch_taken));
      cmp("m_flush_ex", 32'(fex),    32'(m_flush_ex()));
      cmp("m_md_busy",  32'(mdb),    32'(m_busy()));
      cmp("m_cnt16",    32'(scnt),   32'(cnt16));
      cmp("m_cnt3",     32'(scnt_s), 32'(cnt3));
      cmp("m_stall_s",  32'(sid_s),  32'(m_stall()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_a = 0; id_rt_a = 0; ex_rs_a = 0; ex_rt_a = 0; ex_rd_a = 0;
    mem_rd_a = 0; wb_rd_a = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_md_read = 0; id_md_start = 0;
    ex_MemRead = 0; ex_md_start = 0; ex_branch_taken = 0;
    mem_RegWrite = 0; wb_RegWrite = 0;
  endtask

  task automatic set_load_use();
    ex_MemRead = 1; ex_rd_a = 5; id_rt_a = 5; id_uses_rt = 1;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    cmp("rst_md_busy",  32'(mdb),    32'd0);
    cmp("rst_cnt",      32'(scnt),   32'd0);
    cmp("rst_cnt_s",    32'(scnt_s), 32'd0);

    // Forwarding priority
    step();
    mem_rd_a = 3; wb_rd_a = 3; ex_rs_a = 3; mem_RegWrite = 1; wb_RegWrite = 1;
    #1;
    cmp("fwd_mem",      32'(fa), 32'h2);
    cmp("fwd_b_rf",     32'(fb), 32'h0);
    mem_RegWrite = 0;
    #1;
    cmp("fwd_wb",       32'(fa), 32'h1);
    mem_RegWrite = 1; mem_rd_a = 0; wb_rd_a = 0; ex_rs_a = 0;
    #1;
    cmp("fwd_r0",       32'(fa), 32'h0);

    // Load-use: one stall, then the load is forwarded from MEM
    step();
    clear_inputs();
    set_load_use();
    #1;
    cmp("lu_stall_if",  32'(sif), 32'd1);
    cmp("lu_stall_id",  32'(sid), 32'd1);
    cmp("lu_flush_ex",  32'(fex), 32'd1);
    cmp("lu_flush_id",  32'(fid), 32'd0);
    step();
    clear_inputs();
    mem_rd_a = 5; mem_RegWrite = 1; ex_rt_a = 5;
    #1;
    cmp("lu_released",  32'(sid), 32'd0);
    cmp("lu_fwd_mem",   32'(fb),  32'h2);
    cmp("lu_cnt",       32'(scnt), 32'd1);
    step();
    clear_inputs();
    set_load_use();
    id_uses_rt = 0;
    #1;
    cmp("lu_no_use",    32'(sid), 32'd0);
    ex_rd_a = 0; id_rt_a = 0; id_uses_rt = 1;
    #1;
    cmp("lu_r0",        32'(sid), 32'd0);

    // Mul/div busy window
    step();
    clear_inputs();
    ex_md_start = 1;
    step();
    ex_md_start = 0;
    id_md_read  = 1;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      cmp($sformatf("md_stall_t%0d", k), 32'(sid), 32'd1);
      cmp($sformatf("md_busy_t%0d", k),  32'(mdb), 32'd1);
      step();
    end
    #1;
    cmp("md_release",   32'(sid),  32'd0);
    cmp("md_idle",      32'(mdb),  32'd0);
    cmp("md_cnt",       32'(scnt), 32'd5);

    // Branch overrides a load-use stall
    step();
    clear_inputs();
    set_load_use();
    ex_branch_taken = 1;
    #1;
    cmp("br_flush_id",  32'(fid), 32'd1);
    cmp("br_flush_ex",  32'(fex), 32'd1);
    cmp("br_stall_if",  32'(sif), 32'd0);
    cmp("br_stall_id",  32'(sid), 32'd0);
    step();
    clear_inputs();
    #1;
    cmp("br_cnt",       32'(scnt), 32'd5);

    // Reset in the middle of a mul/div window
    ex_md_start = 1;
    step();
    ex_md_start = 0;
    #1;
    cmp("rm_busy_pre",  32'(mdb), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    cmp("rm_busy_async", 32'(mdb),  32'd0);
    cmp("rm_cnt_async",  32'(scnt), 32'd0);
    step();
    rst_n = 1'b1;
    id_md_read = 1;
    #1;
    cmp("rm_no_stall0", 32'(sid), 32'd0);
    step();
    #1;
    cmp("rm_no_stall1", 32'(sid), 32'd0);
    cmp("rm_busy_post", 32'(mdb), 32'd0);

    // Stall counter saturation on the 3-bit instance
    step();
    clear_inputs();
    set_load_use();
    repeat (10) step();
    clear_inputs();
    #1;
    cmp("sat_cnt3",     32'(scnt_s), 32'd7);
    cmp("sat_cnt16",    32'(scnt),   32'd10);

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
